// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Purpose  : Multi-cycle ALU with a valid/ready handshake. Define
//            SEQ_ALU_MULDIV_EN to build the iterative MUL/MULHU/DIVU/REMU path.
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            ALUControl,
  input  logic [DATA_WIDTH-1:0] ALUSrcA,
  input  logic [DATA_WIDTH-1:0] ALUSrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero
);

  localparam int c_SHAMT_W = $clog2(DATA_WIDTH);
  localparam int c_CNT_W   = c_SHAMT_W + 1;

  localparam logic [3:0] c_OP_ADD   = 4'b0000;
  localparam logic [3:0] c_OP_SUB   = 4'b0001;
  localparam logic [3:0] c_OP_AND   = 4'b0010;
  localparam logic [3:0] c_OP_OR    = 4'b0011;
  localparam logic [3:0] c_OP_PASSB = 4'b0100;
  localparam logic [3:0] c_OP_XOR   = 4'b0101;
  localparam logic [3:0] c_OP_SLL   = 4'b0110;
  localparam logic [3:0] c_OP_SRL   = 4'b0111;
  localparam logic [3:0] c_OP_SRA   = 4'b1000;
  localparam logic [3:0] c_OP_SLT   = 4'b1001;
  localparam logic [3:0] c_OP_SLTU  = 4'b1010;
  localparam logic [3:0] c_OP_MUL   = 4'b1011;
  localparam logic [3:0] c_OP_MULHU = 4'b1100;
  localparam logic [3:0] c_OP_DIVU  = 4'b1101;
  localparam logic [3:0] c_OP_REMU  = 4'b1110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic                  r_zero;
  logic [DATA_WIDTH-1:0] r_result;

  logic [DATA_WIDTH-1:0] w_single_res;
  logic [c_SHAMT_W-1:0]  w_shamt;
  logic                  w_eq;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign ALUResult = r_result;
  assign Zero      = r_zero;

  // Single-cycle results come straight from the live inputs on the accept edge.
  always_comb begin
    w_shamt = ALUSrcB[c_SHAMT_W-1:0];
    w_eq    = (ALUSrcA == ALUSrcB);
    case (ALUControl)
      c_OP_ADD:   w_single_res = ALUSrcA + ALUSrcB;
      c_OP_SUB:   w_single_res = ALUSrcA - ALUSrcB;
      c_OP_AND:   w_single_res = ALUSrcA & ALUSrcB;
      c_OP_OR:    w_single_res = ALUSrcA | ALUSrcB;
      c_OP_PASSB: w_single_res = ALUSrcB;
      c_OP_XOR:   w_single_res = ALUSrcA ^ ALUSrcB;
      c_OP_SLL:   w_single_res = ALUSrcA << w_shamt;
      c_OP_SRL:   w_single_res = ALUSrcA >> w_shamt;
      c_OP_SRA:   w_single_res = $unsigned($signed(ALUSrcA) >>> w_shamt);
      c_OP_SLT:   w_single_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(ALUSrcA) < $signed(ALUSrcB))};
      c_OP_SLTU:  w_single_res = {{(DATA_WIDTH-1){1'b0}}, (ALUSrcA < ALUSrcB)};
      default:    w_single_res = '0;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(DATA_WIDTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic [3:0]              r_op;
  logic [DATA_WIDTH-1:0]   r_a;
  logic [DATA_WIDTH-1:0]   r_b;
  logic                    r_eq;
  logic [c_CNT_W-1:0]      r_cnt;
  logic [2*DATA_WIDTH-1:0] r_acc;

  logic                    w_is_multi;
  logic                    w_busy_div;
  logic [2*DATA_WIDTH-1:0] w_mul_next;
  logic [DATA_WIDTH:0]     w_div_part;
  logic [DATA_WIDTH:0]     w_div_diff;
  logic                    w_div_ge;
  logic [DATA_WIDTH-1:0]   w_div_rem;
  logic [DATA_WIDTH-1:0]   w_div_quo;
  logic [DATA_WIDTH-1:0]   w_busy_res;

  // MUL consumes the multiplier MSB-first; DIVU keeps {remainder, quotient} in r_acc.
  always_comb begin
    w_is_multi = (ALUControl == c_OP_MUL) || (ALUControl == c_OP_MULHU) ||
                 (ALUControl == c_OP_DIVU) || (ALUControl == c_OP_REMU);
    w_busy_div = (r_op == c_OP_DIVU) || (r_op == c_OP_REMU);
    w_mul_next = {r_acc[2*DATA_WIDTH-2:0], 1'b0} +
                 (r_b[DATA_WIDTH-1] ? {{DATA_WIDTH{1'b0}}, r_a} : {(2*DATA_WIDTH){1'b0}});
    w_div_part = r_acc[2*DATA_WIDTH-1:DATA_WIDTH-1];
    w_div_diff = w_div_part - {1'b0, r_b};
    w_div_ge   = ~w_div_diff[DATA_WIDTH];
    w_div_rem  = w_div_ge ? w_div_diff[DATA_WIDTH-1:0] : w_div_part[DATA_WIDTH-1:0];
    w_div_quo  = {r_acc[DATA_WIDTH-2:0], w_div_ge};
    case (r_op)
      c_OP_MUL:   w_busy_res = w_mul_next[DATA_WIDTH-1:0];
      c_OP_MULHU: w_busy_res = w_mul_next[2*DATA_WIDTH-1:DATA_WIDTH];
      c_OP_DIVU:  w_busy_res = w_div_quo;
      c_OP_REMU:  w_busy_res = w_div_rem;
      default:    w_busy_res = '0;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_eq        <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
            if (w_is_multi) begin
              r_state <= S_BUSY;
              r_op    <= ALUControl;
              r_a     <= ALUSrcA;
              r_b     <= ALUSrcB;
              r_eq    <= w_eq;
              r_cnt   <= c_CNT_LOAD;
              r_acc   <= ((ALUControl == c_OP_DIVU) || (ALUControl == c_OP_REMU)) ?
                         {{DATA_WIDTH{1'b0}}, ALUSrcA} : {(2*DATA_WIDTH){1'b0}};
            end else
`endif
            begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_single_res;
              r_zero      <= w_eq;
            end
          end
        end
`ifdef SEQ_ALU_MULDIV_EN
        S_BUSY: begin
          r_cnt <= r_cnt - c_CNT_ONE;
          if (w_busy_div) begin
            r_acc <= {w_div_rem, w_div_quo};
          end else begin
            r_acc <= w_mul_next;
            r_b   <= {r_b[DATA_WIDTH-2:0], 1'b0};
          end
          // The last iteration's result is taken combinationally to save a cycle.
          if (r_cnt == c_CNT_ONE) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_busy_res;
            r_zero      <= r_eq;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// tb_seq_alu: directed and randomized checks of seq_alu against an arithmetic
// reference model; mul/div expectations follow SEQ_ALU_MULDIV_EN.
module tb_seq_alu;

  localparam int W        = 32;
  localparam int LONG_LAT = W + 1;
  localparam int MAX_WAIT = 200;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         in_ready;
  logic         out_valid;
  logic         Zero;
  logic [3:0]   ALUControl = 4'd0;
  logic [W-1:0] ALUSrcA = '0;
  logic [W-1:0] ALUSrcB = '0;
  logic [W-1:0] ALUResult;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .Zero       (Zero)
  );

  function automatic bit is_long(input logic [3:0] op);
`ifdef SEQ_ALU_MULDIV_EN
    return (op >= 4'd11) && (op <= 4'd14);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0]   ones;
    logic [2*W-1:0] pa, pb, prod;
    int unsigned    s;
    ones = '1;
    s    = b % W;
    pa   = {{W{1'b0}}, a};
    pb   = {{W{1'b0}}, b};
    prod = pa * pb;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return b;
      4'd5:  return a ^ b;
      4'd6:  return a << s;
      4'd7:  return a >> s;
      4'd8:  return (a >> s) | (a[W-1] ? ~(ones >> s) : '0);
      4'd9:  return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd10: return (a < b) ? 1 : 0;
`ifdef SEQ_ALU_MULDIV_EN
      4'd11: return prod[W-1:0];
      4'd12: return prod[2*W-1:W];
      4'd13: return (b == 0) ? ones : a / b;
      4'd14: return (b == 0) ? a : a % b;
`endif
      default: return '0;
    endcase
  endfunction

  // Issues one request from IDLE and waits (bounded) for out_valid.
  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output logic z, output int lat,
                       output bit rdy_low, output bit idle_ok);
    @(negedge clk);
    ALUControl = op; ALUSrcA = a; ALUSrcB = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    ALUControl = 4'($urandom);
    ALUSrcA    = $urandom;
    ALUSrcB    = $urandom;
    lat        = 1;
    rdy_low    = !in_ready;
    while (!out_valid && lat < MAX_WAIT) begin
      @(posedge clk); #1;
      lat++;
      if (in_ready) rdy_low = 1'b0;
    end
    res     = ALUResult;
    z       = Zero;
    idle_ok = 1'b1;
    if (out_ready) begin
      @(posedge clk); #1;
      idle_ok = in_ready && !out_valid;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (ALUResult !== '0)   begin errors++; $display("FAIL reset_result got %h exp 0", ALUResult); end
    checks++; if (Zero !== 1'b0)      begin errors++; $display("FAIL reset_zero got %b exp 0", Zero); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [3:0]   ops [5];
    logic [W-1:0] as [5];
    logic [W-1:0] bs [5];
    logic [W-1:0] ex [5];
    logic         zs [5];
    logic [W-1:0] res;
    logic         z;
    int           lat;
    bit           rl, io;
    ops = '{4'd1, 4'd8, 4'd9, 4'd10, 4'd4};
    as  = '{32'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
    bs  = '{32'd7, 32'h21, 32'd1, 32'd1, 32'd3};
    ex  = '{32'hFFFF_FFFE, 32'hC000_0000, 32'd1, 32'd0, 32'd3};
    zs  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], as[i], bs[i], res, z, lat, rl, io);
      checks++; if (res !== ex[i]) begin errors++; $display("FAIL dir_res[%0d] got %h exp %h", i, res, ex[i]); end
      checks++; if (z !== zs[i])   begin errors++; $display("FAIL dir_zero[%0d] got %b exp %b", i, z, zs[i]); end
      checks++; if (lat !== 1)     begin errors++; $display("FAIL dir_lat[%0d] got %0d exp 1", i, lat); end
    end
  endtask

  task automatic test_random;
    logic [3:0]   op;
    logic [W-1:0] a, b, res;
    logic         z;
    int           lat, exp_lat;
    bit           rl, io;
    out_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = a;
        1:       b = '0;
        2:       b = $urandom_range(0, 70);
        default: b = $urandom;
      endcase
      exp_lat = is_long(op) ? LONG_LAT : 1;
      drive(op, a, b, res, z, lat, rl, io);
      checks++; if (res !== model(op, a, b)) begin errors++; $display("FAIL rand_res op=%0d a=%h b=%h got %h exp %h", op, a, b, res, model(op, a, b)); end
      checks++; if (z !== (a == b))     begin errors++; $display("FAIL rand_zero op=%0d got %b exp %b", op, z, (a == b)); end
      checks++; if (lat !== exp_lat)    begin errors++; $display("FAIL rand_lat op=%0d got %0d exp %0d", op, lat, exp_lat); end
      checks++; if (!rl)                begin errors++; $display("FAIL rand_in_ready op=%0d in_ready went high before handshake", op); end
      checks++; if (!io)                begin errors++; $display("FAIL rand_idle op=%0d in_ready=%b out_valid=%b after handshake", op, in_ready, out_valid); end
    end
  endtask

  task automatic test_muldiv;
    logic [3:0]   ops [6];
    logic [W-1:0] as [6];
    logic [W-1:0] bs [6];
    logic [W-1:0] ex [6];
    logic [W-1:0] res;
    logic         z;
    int           lat, exp_lat;
    bit           rl, io;
`ifdef SEQ_ALU_MULDIV_EN
    ops = '{4'd11, 4'd12, 4'd13, 4'd14, 4'd13, 4'd14};
    as  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'd100, 32'd100};
    bs  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'd0, 32'd0};
    ex  = '{32'd1, 32'hFFFF_FFFE, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd100};
    exp_lat = LONG_LAT;
`else
    ops = '{4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd11};
    as  = '{32'd3, 32'd3, 32'd100, 32'd100, 32'd9, 32'd6};
    bs  = '{32'd4, 32'd4, 32'd7, 32'd7, 32'd9, 32'd6};
    ex  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    exp_lat = 1;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], as[i], bs[i], res, z, lat, rl, io);
      checks++; if (res !== ex[i])   begin errors++; $display("FAIL md_res[%0d] op=%0d got %h exp %h", i, ops[i], res, ex[i]); end
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL md_lat[%0d] got %0d exp %0d", i, lat, exp_lat); end
      checks++; if (!rl)             begin errors++; $display("FAIL md_in_ready[%0d] in_ready high before handshake", i); end
      checks++; if (z !== (as[i] == bs[i])) begin errors++; $display("FAIL md_zero[%0d] got %b exp %b", i, z, (as[i] == bs[i])); end
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] res;
    logic         z;
    int           lat;
    bit           rl, io;
    out_ready = 1'b0;
    drive(4'd0, 32'd10, 32'd20, res, z, lat, rl, io);
    checks++; if (res !== 32'd30) begin errors++; $display("FAIL bp_res got %h exp 1e", res); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; ALUControl = 4'd5; ALUSrcA = $urandom; ALUSrcB = $urandom;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1)  begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", i, out_valid); end
      checks++; if (ALUResult !== 32'd30) begin errors++; $display("FAIL bp_hold[%0d] got %h exp 1e", i, ALUResult); end
      checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, in_ready); end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL bp_release_valid got %b exp 0", out_valid); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL bp_not_queued got %b exp 0", out_valid); end
    checks++; if (ALUResult !== 32'd30) begin errors++; $display("FAIL bp_idle_hold got %h exp 1e", ALUResult); end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] res;
    logic         z;
    int           lat;
    bit           rl, io;
    out_ready = 1'b1;
    drive(4'd0, 32'd5, 32'd5, res, z, lat, rl, io);
`ifdef SEQ_ALU_MULDIV_EN
    @(negedge clk);
    ALUControl = 4'd13; ALUSrcA = 32'd1000; ALUSrcB = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
`else
    out_ready = 1'b0;
    drive(4'd0, 32'd7, 32'd7, res, z, lat, rl, io);
    @(posedge clk);
`endif
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rstmid_ready got %b exp 1", in_ready); end
    checks++; if (ALUResult !== '0)   begin errors++; $display("FAIL rstmid_result got %h exp 0", ALUResult); end
    checks++; if (Zero !== 1'b0)      begin errors++; $display("FAIL rstmid_zero got %b exp 0", Zero); end
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    drive(4'd1, 32'd9, 32'd4, res, z, lat, rl, io);
    checks++; if (res !== 32'd5) begin errors++; $display("FAIL rstmid_after_res got %h exp 5", res); end
    checks++; if (lat !== 1)     begin errors++; $display("FAIL rstmid_after_lat got %0d exp 1", lat); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_muldiv();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
